// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-step shift/rotate engine.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_LSL = 3'b000,
        OP_LSR = 3'b001,
        OP_ASR = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } shift_state_e;

    // Op codes at or above this value hold data and ser_out but still consume steps.
    localparam logic [2:0] OP_RESERVED_MIN = 3'b101;

    function automatic logic op_is_reserved(input logic [2:0] op);
        return op >= OP_RESERVED_MIN;
    endfunction

endpackage

// File: rtl/shift_engine_if.sv
// Request/result handshake bundle between a front end and the shift engine.
interface shift_engine_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned AW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_op;
    logic [AW-1:0]    in_amount;
    logic             ser_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             ser_out;
    logic             busy;

    modport master (
        output in_valid, in_data, in_op, in_amount, ser_in, out_ready,
        input  in_ready, out_valid, data_out, ser_out, busy
    );

    modport slave (
        input  in_valid, in_data, in_op, in_amount, ser_in, out_ready,
        output in_ready, out_valid, data_out, ser_out, busy
    );

endinterface

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step; reserved ops pass the word through.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic [2:0]       op,
    input  logic             fill,
    output logic [WIDTH-1:0] d_next,
    output logic             out_bit
);

    always_comb begin
        d_next  = d;
        out_bit = 1'b0;
        case (op)
            OP_LSL: begin
                d_next  = {d[WIDTH-2:0], fill};
                out_bit = d[WIDTH-1];
            end
            OP_LSR: begin
                d_next  = {fill, d[WIDTH-1:1]};
                out_bit = d[0];
            end
            OP_ASR: begin
                d_next  = {d[WIDTH-1], d[WIDTH-1:1]};
                out_bit = d[0];
            end
            OP_ROL: begin
                d_next  = {d[WIDTH-2:0], d[WIDTH-1]};
                out_bit = d[WIDTH-1];
            end
            OP_ROR: begin
                d_next  = {d[0], d[WIDTH-1:1]};
                out_bit = d[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_engine.sv
// Multi-step shift/rotate engine: accepts a word, shifts one bit per clock, then
// holds the result until the consumer takes it.
module shift_engine
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_engine_if.slave  bus
);

    localparam int unsigned AW = $clog2(WIDTH);

    shift_state_e     state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       op_q, op_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             ser_q, ser_d;
    logic [WIDTH-1:0] step_data;
    logic             step_out;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .d       (data_q),
        .op      (op_q),
        .fill    (bus.ser_in),
        .d_next  (step_data),
        .out_bit (step_out)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        ser_d   = ser_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    op_d    = bus.in_op;
                    cnt_d   = bus.in_amount;
                    state_d = (bus.in_amount == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_q - AW'(1);
                // Reserved ops burn the same number of cycles without touching the word.
                if (!op_is_reserved(op_q)) begin
                    data_d = step_data;
                    ser_d  = step_out;
                end
                if (cnt_q == AW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            op_q    <= OP_LSL;
            cnt_q   <= '0;
            ser_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.data_out  = data_q;
    assign bus.ser_out   = ser_q;

endmodule

// File: tb/tb_shift_engine.sv
// Self-checking bench for shift_engine: directed scenarios plus randomized ops
// checked against an arithmetic reference model.
module tb_shift_engine;
    import shift_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned AW = $clog2(W);

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    logic ser_model;

    shift_engine_if #(.WIDTH(W)) bus ();

    shift_engine #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Whole-operation result {ser_out, data} from shift arithmetic on the full amount.
    function automatic logic [W:0] ref_op(input logic [W-1:0] d, input logic [2:0] op,
                                          input int n, input logic fill, input logic ser_prev);
        logic [31:0] v;
        logic [31:0] m;
        logic [31:0] hi;
        logic [31:0] res;
        logic        s;
        v   = 32'(d);
        m   = (32'd1 << W) - 32'd1;
        hi  = m & ~(m >> n);
        res = v;
        s   = ser_prev;
        if (n == 0 || op > 3'd4) return {ser_prev, d};
        case (op)
            3'd0: begin res = ((v << n) | (fill ? ((32'd1 << n) - 32'd1) : 32'd0)) & m;
                        s = v[W-n]; end
            3'd1: begin res = (v >> n) | (fill ? hi : 32'd0); s = v[n-1]; end
            3'd2: begin res = (v >> n) | (d[W-1] ? hi : 32'd0); s = v[n-1]; end
            3'd3: begin res = ((v << n) | (v >> (W - n))) & m; s = res[0]; end
            default: begin res = ((v >> n) | (v << (W - n))) & m; s = res[W-1]; end
        endcase
        return {s, res[W-1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [2:0] op, input int amt,
                        input logic fill);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_op     = op;
        bus.in_amount = AW'(amt);
        bus.ser_in    = fill;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 4 * W) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_op     = 3'b000;
        bus.in_amount = '0;
        bus.ser_in    = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.ser_out, bus.data_out} !== {4'b1000, 8'h00}) begin
            n_err++;
            $display("FAIL reset_values: got rdy/vld/busy/ser/data=%b%b%b%b/%h, want 1000/00",
                     bus.in_ready, bus.out_valid, bus.busy, bus.ser_out, bus.data_out);
        end
        #1 rst_n = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.ser_out, bus.data_out} !== {4'b1000, 8'h00}) begin
            n_err++;
            $display("FAIL idle_values: got rdy/vld/busy/ser/data=%b%b%b%b/%h, want 1000/00",
                     bus.in_ready, bus.out_valid, bus.busy, bus.ser_out, bus.data_out);
        end
    endtask

    task automatic test_lsl();
        int lat;
        send(8'h51, OP_LSL, 3, 1'b0);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 3) begin n_err++; $display("FAIL lsl_latency: got %0d want 3", lat); end
        n_cmp++;
        if ({bus.ser_out, bus.data_out} !== {1'b0, 8'h88}) begin
            n_err++;
            $display("FAIL lsl_result: got ser=%b data=%h want ser=0 data=88", bus.ser_out, bus.data_out);
        end
        release_out();
    endtask

    task automatic test_asr_handshake();
        int lat;
        send(8'h90, OP_ASR, 2, 1'b0);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 2) begin n_err++; $display("FAIL asr_latency: got %0d want 2", lat); end
        n_cmp++;
        if ({bus.ser_out, bus.data_out} !== {1'b0, 8'hE4}) begin
            n_err++;
            $display("FAIL asr_result: got ser=%b data=%h want ser=0 data=e4", bus.ser_out, bus.data_out);
        end
        n_cmp++;
        if ({bus.in_ready, bus.busy} !== 2'b01) begin
            n_err++;
            $display("FAIL asr_done_flags: got rdy/busy=%b%b want 01", bus.in_ready, bus.busy);
        end
        release_out();
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            n_err++;
            $display("FAIL asr_after_handshake: got rdy/vld/busy=%b%b%b want 100",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_rotate();
        int lat;
        send(8'h81, OP_ROL, 7, 1'b0);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 7 || {bus.ser_out, bus.data_out} !== {1'b0, 8'hC0}) begin
            n_err++;
            $display("FAIL rol_result: got lat=%0d ser=%b data=%h want lat=7 ser=0 data=c0",
                     lat, bus.ser_out, bus.data_out);
        end
        release_out();
        send(8'h81, OP_ROR, 1, 1'b0);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 1 || {bus.ser_out, bus.data_out} !== {1'b1, 8'hC0}) begin
            n_err++;
            $display("FAIL ror_result: got lat=%0d ser=%b data=%h want lat=1 ser=1 data=c0",
                     lat, bus.ser_out, bus.data_out);
        end
        release_out();
    endtask

    task automatic test_lsr_abort();
        int lat;
        send(8'h0F, OP_LSR, 4, 1'b1);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 4 || {bus.ser_out, bus.data_out} !== {1'b1, 8'hF0}) begin
            n_err++;
            $display("FAIL lsr_result: got lat=%0d ser=%b data=%h want lat=4 ser=1 data=f0",
                     lat, bus.ser_out, bus.data_out);
        end
        release_out();
        send(8'h0F, OP_LSR, 4, 1'b1);
        tick();
        tick();
        n_cmp++;
        if ({bus.busy, bus.data_out} !== {1'b1, 8'hC3}) begin
            n_err++;
            $display("FAIL abort_midway: got busy=%b data=%h want busy=1 data=c3",
                     bus.busy, bus.data_out);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.ser_out, bus.data_out} !== {4'b1000, 8'h00}) begin
            n_err++;
            $display("FAIL abort_reset: got rdy/vld/busy/ser/data=%b%b%b%b/%h, want 1000/00",
                     bus.in_ready, bus.out_valid, bus.busy, bus.ser_out, bus.data_out);
        end
        #3 rst_n = 1'b1;
        bus.ser_in = 1'b0;
        tick();
        n_cmp++;
        if ({bus.in_ready, bus.busy, bus.data_out} !== {2'b10, 8'h00}) begin
            n_err++;
            $display("FAIL abort_recover: got rdy/busy/data=%b%b/%h want 10/00",
                     bus.in_ready, bus.busy, bus.data_out);
        end
    endtask

    task automatic test_zero_stall();
        int lat;
        send(8'hA5, OP_LSR, 0, 1'b0);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 0) begin n_err++; $display("FAIL zero_latency: got %0d want 0", lat); end
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            bus.ser_in   = ~bus.ser_in;
            tick();
            n_cmp++;
            if ({bus.out_valid, bus.in_ready, bus.ser_out, bus.data_out} !== {3'b100, 8'hA5}) begin
                n_err++;
                $display("FAIL zero_stall_%0d: got vld/rdy/ser/data=%b%b%b/%h want 100/a5",
                         i, bus.out_valid, bus.in_ready, bus.ser_out, bus.data_out);
            end
        end
        bus.in_valid = 1'b0;
        release_out();
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            n_err++;
            $display("FAIL zero_release: got rdy/vld/busy=%b%b%b want 100",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
    endtask

    // Back-to-back random requests, including reserved ops and random consumer stalls.
    task automatic test_random();
        logic [W-1:0] d;
        logic [2:0]   op;
        logic         fill;
        logic [W:0]   exp;
        int           amt;
        int           lat;
        ser_model = 1'b0;
        for (int i = 0; i < 60; i++) begin
            d    = W'($urandom);
            op   = 3'($urandom_range(0, 7));
            amt  = int'($urandom_range(0, W - 1));
            fill = 1'($urandom_range(0, 1));
            exp  = ref_op(d, op, amt, fill, ser_model);
            send(d, op, amt, fill);
            wait_valid(lat);
            n_cmp++;
            if (lat !== amt) begin
                n_err++;
                $display("FAIL rand_latency_%0d: op=%0d amt=%0d got %0d", i, op, amt, lat);
            end
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                bus.ser_in = ~bus.ser_in;
                tick();
            end
            n_cmp++;
            if ({bus.ser_out, bus.data_out} !== exp) begin
                n_err++;
                $display("FAIL rand_result_%0d: op=%0d d=%h amt=%0d fill=%b got ser=%b data=%h want ser=%b data=%h",
                         i, op, d, amt, fill, bus.ser_out, bus.data_out, exp[W], exp[W-1:0]);
            end
            ser_model = exp[W];
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_lsl();
        test_asr_handshake();
        test_rotate();
        test_lsr_abort();
        test_zero_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
